// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, funct3 encodings,
// interrupt codes, register bit positions and the write-combining helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  // funct3[1:0] selects the operation; bit 2 only distinguishes the immediate form
  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_RW   = 2'b01,
    KIND_RS   = 2'b10,
    KIND_RC   = 2'b11
  } csr_kind_e;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  localparam int MIE_MSIE_BIT = 3;
  localparam int MIE_MTIE_BIT = 7;
  localparam int MIE_MEIE_BIT = 11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  function automatic logic [63:0] csr_apply(input csr_kind_e kind,
                                            input logic [63:0] old_val,
                                            input logic [63:0] wdata);
    logic [63:0] res;
    case (kind)
      KIND_RW: res = wdata;
      KIND_RS: res = old_val | wdata;
      KIND_RC: res = old_val & ~wdata;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_file_m_counter64.sv
// 64-bit free-running counter with independent half writes; any write
// suppresses the increment for that cycle so the written value is held.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [63:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata[31:0];
      if (wr_hi) count[63:32] <= wdata[63:32];
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSR read/modify/write, trap entry and MRET,
// 64-bit cycle/instret counters and interrupt pending/cause generation.
module csr_file_m
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter bit              VECTORED_EN = 1'b1,
  parameter int              HART_ID     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_src_zero,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_rdata_valid,
  output logic            csr_illegal,
  input  logic            instret_inc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_valid,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] epc_out,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic            irq_pending,
  output logic [XLEN-1:0] irq_cause
);

  logic            mstatus_mie, mstatus_mpie;
  logic            mie_meie, mie_mtie, mie_msie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0]     mcycle, minstret;

  logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;
  logic [XLEN-1:0] old_val;
  logic            addr_ok;
  csr_kind_e       kind;
  logic            op_ok, wr_req, illegal, csr_we;
  logic [63:0]     wval64;
  logic [XLEN-1:0] wval;

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie;
    mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mie_rd = '0;
    mie_rd[MIE_MEIE_BIT] = mie_meie;
    mie_rd[MIE_MTIE_BIT] = mie_mtie;
    mie_rd[MIE_MSIE_BIT] = mie_msie;

    mip_rd = '0;
    mip_rd[MIE_MEIE_BIT] = irq_ext;
    mip_rd[MIE_MTIE_BIT] = irq_timer;
    mip_rd[MIE_MSIE_BIT] = irq_sw;
  end

  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   old_val = mstatus_rd;
      CSR_MIE:       old_val = mie_rd;
      CSR_MTVEC:     old_val = mtvec;
      CSR_MSCRATCH:  old_val = mscratch;
      CSR_MEPC:      old_val = mepc;
      CSR_MCAUSE:    old_val = mcause;
      CSR_MTVAL:     old_val = mtval;
      CSR_MIP:       old_val = mip_rd;
      CSR_MCYCLE:    old_val = mcycle[XLEN-1:0];
      CSR_MINSTRET:  old_val = minstret[XLEN-1:0];
      CSR_MCYCLEH: begin
        old_val = XLEN'(mcycle[63:32]);
        addr_ok = (XLEN == 32);
      end
      CSR_MINSTRETH: begin
        old_val = XLEN'(minstret[63:32]);
        addr_ok = (XLEN == 32);
      end
      CSR_MHARTID:   old_val = XLEN'(HART_ID);
      default:       addr_ok = 1'b0;
    endcase
  end

  // Set/clear forms with a zero source are pure reads, so they never write
  // and never trip the read-only check.
  always_comb begin
    kind    = csr_kind_e'(csr_op[1:0]);
    op_ok   = (kind != KIND_NONE);
    wr_req  = op_ok && ((kind == KIND_RW) || !csr_src_zero);
    illegal = !op_ok || !addr_ok || (wr_req && (csr_addr[11:10] == 2'b11));
    csr_we  = csr_valid && wr_req && !illegal && !trap_valid && !mret_valid;
    wval64  = csr_apply(kind, 64'(old_val), 64'(csr_wdata));
    wval    = wval64[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_msie     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else if (trap_valid) begin
      mepc         <= {trap_pc[XLEN-1:2], 2'b00};
      mcause       <= trap_cause;
      mtval        <= trap_val;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= wval[MSTATUS_MIE_BIT];
          mstatus_mpie <= wval[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mie_meie <= wval[MIE_MEIE_BIT];
          mie_mtie <= wval[MIE_MTIE_BIT];
          mie_msie <= wval[MIE_MSIE_BIT];
        end
        CSR_MTVEC: begin
          mtvec[XLEN-1:2] <= wval[XLEN-1:2];
          mtvec[1:0] <= (VECTORED_EN && (wval[1:0] == MTVEC_MODE_VECTORED)) ?
                        MTVEC_MODE_VECTORED : MTVEC_MODE_DIRECT;
        end
        CSR_MSCRATCH: mscratch <= wval;
        CSR_MEPC:     mepc     <= {wval[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause   <= wval;
        CSR_MTVAL:    mtval    <= wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rdata       <= '0;
      csr_rdata_valid <= 1'b0;
      csr_illegal     <= 1'b0;
    end else begin
      csr_rdata_valid <= csr_valid;
      csr_illegal     <= csr_valid && illegal;
      if (csr_valid) csr_rdata <= illegal ? '0 : old_val;
    end
  end

  // High-half addresses carry the XLEN=32 write data in the upper word.
  logic        hi_addr;
  logic [63:0] cnt_wdata;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  always_comb begin
    hi_addr   = (csr_addr == CSR_MCYCLEH) || (csr_addr == CSR_MINSTRETH);
    cnt_wdata = hi_addr ? {wval64[31:0], 32'h0} : wval64;
    cyc_wr_lo = csr_we && (csr_addr == CSR_MCYCLE);
    cyc_wr_hi = csr_we && ((csr_addr == CSR_MCYCLEH) ||
                           ((XLEN == 64) && (csr_addr == CSR_MCYCLE)));
    ins_wr_lo = csr_we && (csr_addr == CSR_MINSTRET);
    ins_wr_hi = csr_we && ((csr_addr == CSR_MINSTRETH) ||
                           ((XLEN == 64) && (csr_addr == CSR_MINSTRET)));
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (cnt_wdata),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_inc),
    .wr_lo (ins_wr_lo),
    .wr_hi (ins_wr_hi),
    .wdata (cnt_wdata),
    .count (minstret)
  );

  logic [XLEN-1:0] tvec_base, cause_x4;

  always_comb begin
    tvec_base = {mtvec[XLEN-1:2], 2'b00};
    cause_x4  = XLEN'({trap_cause[XLEN-2:0], 2'b00});
    if ((mtvec[1:0] == MTVEC_MODE_VECTORED) && trap_cause[XLEN-1])
      trap_target = tvec_base + cause_x4;
    else
      trap_target = tvec_base;
    epc_out = mepc;
  end

  logic [2:0] pend;

  // Cause priority is external, then software, then timer.
  always_comb begin
    pend        = {irq_ext & mie_meie, irq_sw & mie_msie, irq_timer & mie_mtie};
    irq_pending = mstatus_mie && (|pend);
    irq_cause   = '0;
    if (irq_pending) begin
      irq_cause[XLEN-1] = 1'b1;
      if (pend[2])      irq_cause[3:0] = IRQ_CODE_MEI;
      else if (pend[1]) irq_cause[3:0] = IRQ_CODE_MSI;
      else              irq_cause[3:0] = IRQ_CODE_MTI;
    end
  end

endmodule

// File: tb/tb_csr_file_m.sv
// Directed bench for csr_file_m (XLEN=32, MTVEC_RESET=0x1000, HART_ID=7)
// with hand-computed expectations checked by immediate assertions.
module tb_csr_file_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic [31:0] csr_rdata;
  logic        csr_rdata_valid;
  logic        csr_illegal;
  logic        instret_inc;
  logic        trap_valid;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic        mret_valid;
  logic [31:0] trap_target, epc_out;
  logic        irq_ext, irq_timer, irq_sw;
  logic        irq_pending;
  logic [31:0] irq_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_file_m #(
    .XLEN(32), .MTVEC_RESET(32'h0000_1000), .VECTORED_EN(1'b1), .HART_ID(7)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero),
    .csr_rdata(csr_rdata), .csr_rdata_valid(csr_rdata_valid),
    .csr_illegal(csr_illegal), .instret_inc(instret_inc),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_val(trap_val), .mret_valid(mret_valid),
    .trap_target(trap_target), .epc_out(epc_out),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .irq_pending(irq_pending), .irq_cause(irq_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] addr,
                     input logic [31:0] wd, input logic sz);
    csr_valid    = 1'b1;
    csr_op       = op;
    csr_addr     = addr;
    csr_wdata    = wd;
    csr_src_zero = sz;
    tick();
    csr_valid    = 1'b0;
    csr_src_zero = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr);
    csr(3'b010, addr, 32'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; csr_valid = 0; csr_addr = 0; csr_op = 0; csr_wdata = 0;
    csr_src_zero = 0; instret_inc = 0; trap_valid = 0; trap_cause = 0;
    trap_pc = 0; trap_val = 0; mret_valid = 0; irq_ext = 0; irq_timer = 0;
    irq_sw = 0;
    tick(); tick();
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_valid", {31'h0, csr_rdata_valid}, 32'h0);
    chk("rst_illegal", {31'h0, csr_illegal}, 32'h0);
    chk("rst_target", trap_target, 32'h0000_1000);
    chk("rst_epc", epc_out, 32'h0);
    rst = 1'b0;
    tick();

    // basic read/write and latency
    csr(3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0);
    chk("rw_old", csr_rdata, 32'h0);
    chk("rw_valid", {31'h0, csr_rdata_valid}, 32'h1);
    csr(3'b010, 12'h340, 32'h0000_000F, 1'b0);
    chk("rs_old", csr_rdata, 32'hDEAD_BEEF);
    tick();
    chk("valid_drop", {31'h0, csr_rdata_valid}, 32'h0);
    rd(12'h340);
    chk("mscratch", csr_rdata, 32'hDEAD_BEEF);

    // write suppression, illegal accesses
    csr(3'b001, 12'h305, 32'h0000_0104, 1'b0);
    chk("mtvec_rst", csr_rdata, 32'h0000_1000);
    csr(3'b011, 12'h305, 32'hFFFF_FFFF, 1'b1);
    chk("rc_zero_old", csr_rdata, 32'h0000_0104);
    rd(12'h305);
    chk("mtvec_kept", csr_rdata, 32'h0000_0104);
    csr(3'b001, 12'hF14, 32'h5, 1'b0);
    chk("hartid_wr_ill", {31'h0, csr_illegal}, 32'h1);
    chk("hartid_wr_data", csr_rdata, 32'h0);
    rd(12'hF14);
    chk("hartid_rd_ill", {31'h0, csr_illegal}, 32'h0);
    chk("hartid", csr_rdata, 32'h7);
    rd(12'h7C0);
    chk("unimpl_ill", {31'h0, csr_illegal}, 32'h1);
    csr(3'b100, 12'h340, 32'h1, 1'b0);
    chk("op100_ill", {31'h0, csr_illegal}, 32'h1);
    chk("op100_data", csr_rdata, 32'h0);
    csr(3'b001, 12'h344, 32'hFFF, 1'b0);
    chk("mip_wr_ill", {31'h0, csr_illegal}, 32'h0);
    chk("mip_wr_data", csr_rdata, 32'h0);

    // trap entry and MRET
    csr(3'b001, 12'h300, 32'h8, 1'b0);
    chk("mstatus_rst", csr_rdata, 32'h0000_1800);
    rd(12'h300);
    chk("mstatus_mie", csr_rdata, 32'h0000_1808);
    trap_valid = 1; trap_cause = 32'h2; trap_pc = 32'h103; trap_val = 32'h55;
    tick();
    trap_valid = 0;
    chk("trap_epc", epc_out, 32'h100);
    rd(12'h300);
    chk("trap_mstatus", csr_rdata, 32'h0000_1880);
    rd(12'h342);
    chk("trap_mcause", csr_rdata, 32'h2);
    rd(12'h343);
    chk("trap_mtval", csr_rdata, 32'h55);
    mret_valid = 1;
    tick();
    mret_valid = 0;
    rd(12'h300);
    chk("mret_mstatus", csr_rdata, 32'h0000_1888);
    chk("mret_epc", epc_out, 32'h100);

    // interrupts and vectored target
    csr(3'b001, 12'h305, 32'h8000_0001, 1'b0);
    csr(3'b001, 12'h304, 32'h80, 1'b0);
    irq_timer = 1; trap_cause = 32'h8000_0007;
    #1;
    chk("irq_pend_t", {31'h0, irq_pending}, 32'h1);
    chk("irq_cause_t", irq_cause, 32'h8000_0007);
    chk("vec_target", trap_target, 32'h8000_001C);
    irq_ext = 1;
    csr(3'b001, 12'h304, 32'h880, 1'b0);
    chk("mie_old", csr_rdata, 32'h80);
    irq_sw = 1;
    #1;
    chk("irq_cause_e", irq_cause, 32'h8000_000B);
    rd(12'h344);
    chk("mip", csr_rdata, 32'h888);
    csr(3'b001, 12'h304, 32'hFFFF_FFFF, 1'b0);
    rd(12'h304);
    chk("mie_mask", csr_rdata, 32'h888);
    irq_ext = 0;
    #1;
    chk("irq_cause_s", irq_cause, 32'h8000_0003);
    trap_cause = 32'h2;
    #1;
    chk("exc_target", trap_target, 32'h8000_0000);
    csr(3'b001, 12'h305, 32'h8000_0003, 1'b0);
    rd(12'h305);
    chk("mtvec_mode3", csr_rdata, 32'h8000_0000);
    trap_cause = 32'h8000_0007;
    #1;
    chk("direct_target", trap_target, 32'h8000_0000);
    csr(3'b011, 12'h300, 32'h8, 1'b0);
    chk("irq_off", {31'h0, irq_pending}, 32'h0);
    chk("irq_cause_0", irq_cause, 32'h0);
    irq_timer = 0; irq_sw = 0;

    // counters
    csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    csr(3'b001, 12'hB80, 32'hFFFF_FFFF, 1'b0);
    tick();
    rd(12'hB00);
    chk("mcycle_wrap", csr_rdata, 32'h0);
    rd(12'hB80);
    chk("mcycleh_wrap", csr_rdata, 32'h0);
    rd(12'hB00);
    chk("mcycle_run", csr_rdata, 32'h2);
    csr(3'b001, 12'hB00, 32'h1234, 1'b0);
    rd(12'hB00);
    chk("mcycle_wr_wins", csr_rdata, 32'h1234);
    instret_inc = 1;
    csr(3'b001, 12'hB02, 32'h5, 1'b0);
    tick(); tick(); tick();
    instret_inc = 0;
    rd(12'hB02);
    chk("minstret", csr_rdata, 32'h8);

    // priority collisions
    trap_valid = 1; trap_pc = 32'h307; trap_cause = 32'h1;
    csr(3'b001, 12'h341, 32'h200, 1'b0);
    trap_valid = 0;
    chk("coll_old_epc", csr_rdata, 32'h100);
    chk("coll_epc", epc_out, 32'h304);
    csr(3'b001, 12'h341, 32'h203, 1'b0);
    chk("epc_align", epc_out, 32'h200);
    csr(3'b010, 12'h300, 32'h8, 1'b0);
    trap_valid = 1; mret_valid = 1; trap_pc = 32'h40;
    tick();
    trap_valid = 0; mret_valid = 0;
    rd(12'h300);
    chk("trap_over_mret", csr_rdata, 32'h0000_1880);
    chk("trap_over_mret_epc", epc_out, 32'h40);

    // reset in the middle of a write
    csr_valid = 1; csr_op = 3'b001; csr_addr = 12'h340; csr_wdata = 32'h1;
    rst = 1;
    tick();
    csr_valid = 0;
    rst = 0;
    chk("midrst_valid", {31'h0, csr_rdata_valid}, 32'h0);
    rd(12'h340);
    chk("midrst_mscratch", csr_rdata, 32'h0);
    rd(12'h305);
    chk("midrst_mtvec", csr_rdata, 32'h0000_1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
